// File: rtl/watch_timekeeper_pkg.sv
// Shared constants, width helper and time record for the watch timekeeper.
package watch_pkg;

  localparam int SEC_MOD_DEF = 60;
  localparam int MIN_MOD_DEF = 60;
  localparam int HR_MOD_DEF  = 24;

  // Widest field any time_t member can carry; field widths must not exceed it.
  localparam int FIELD_W = 8;

  // Smallest width (>=1) able to hold the values 0..n-1.
  function automatic int width_for(input int n);
    int w;
    w = 1;
    for (int i = 0; i < 31; i++) begin
      if ((1 << w) < n) w++;
    end
    return w;
  endfunction

  typedef struct packed {
    logic [FIELD_W-1:0] hr;
    logic [FIELD_W-1:0] min;
    logic [FIELD_W-1:0] sec;
  } time_t;

endpackage

// File: rtl/watch_timekeeper_if.sv
// Control/load/time bus of the watch timekeeper; alarm signals exist only
// when WATCH_TIMEKEEPER_ALARM_EN is defined.
interface watch_timekeeper_if #(
  parameter int SEC_W = 6,
  parameter int MIN_W = 6,
  parameter int HR_W  = 5
);
  // tick is a one-cycle strobe; load is a one-cycle strobe sampled on Clk.
  logic             tick;
  logic             run;
  logic             down;
  logic             load;
  logic [SEC_W-1:0] load_sec;
  logic [MIN_W-1:0] load_min;
  logic [HR_W-1:0]  load_hr;
  logic [SEC_W-1:0] seconds;
  logic [MIN_W-1:0] minutes;
  logic [HR_W-1:0]  hours;
  logic             min_pulse;
  logic             day_pulse;
`ifdef WATCH_TIMEKEEPER_ALARM_EN
  logic             alarm_set;
  logic [HR_W-1:0]  alarm_hr;
  logic [MIN_W-1:0] alarm_min;
  logic             alarm_clr;
  logic             alarm_flag;

  modport master (output tick, run, down, load, load_sec, load_min, load_hr,
                         alarm_set, alarm_hr, alarm_min, alarm_clr,
                  input  seconds, minutes, hours, min_pulse, day_pulse, alarm_flag);
  modport slave  (input  tick, run, down, load, load_sec, load_min, load_hr,
                         alarm_set, alarm_hr, alarm_min, alarm_clr,
                  output seconds, minutes, hours, min_pulse, day_pulse, alarm_flag);
`else
  modport master (output tick, run, down, load, load_sec, load_min, load_hr,
                  input  seconds, minutes, hours, min_pulse, day_pulse);
  modport slave  (input  tick, run, down, load, load_sec, load_min, load_hr,
                  output seconds, minutes, hours, min_pulse, day_pulse);
`endif
endinterface

// File: rtl/watch_timekeeper_mod_counter.sv
// One modulo-MOD up/down time field with load; wrap flags the carry/borrow
// of an enabled step and feeds the next field's enable.
module mod_counter #(
  parameter int MOD = 60,
  parameter int W   = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         dn,
  input  logic         ld,
  input  logic [W-1:0] ld_val,
  output logic [W-1:0] val,
  output logic [W-1:0] nxt,
  output logic         wrap
);

  localparam logic [W-1:0] TOP = W'(MOD - 1);

  logic at_top;
  logic at_zero;

  // Boundary is tested on the current value, before any increment.
  assign at_top  = (val == TOP);
  assign at_zero = (val == '0);
  assign wrap    = en && !ld && (dn ? at_zero : at_top);

  always_comb begin
    nxt = val;
    if (ld) begin
      nxt = ({1'b0, ld_val} > {1'b0, TOP}) ? '0 : ld_val;
    end else if (en) begin
      if (dn) nxt = at_zero ? TOP : val - 1'b1;
      else    nxt = at_top  ? '0  : val + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) val <= '0;
    else     val <= nxt;
  end

endmodule

// File: rtl/watch_timekeeper.sv
// Parametrised hh:mm:ss timekeeper with tick prescaler, up/down, load and
// rollover pulses. Optional hour:minute alarm under WATCH_TIMEKEEPER_ALARM_EN.
import watch_pkg::*;

module watch_timekeeper #(
  parameter int PRESCALE = 1,
  parameter int SEC_MOD  = SEC_MOD_DEF,
  parameter int MIN_MOD  = MIN_MOD_DEF,
  parameter int HR_MOD   = HR_MOD_DEF,
  parameter int SEC_W    = 6,
  parameter int MIN_W    = 6,
  parameter int HR_W     = 5
) (
  input  logic               Clk,
  input  logic               reset,
  watch_timekeeper_if.slave  bus
);

  localparam int            PS_W   = width_for(PRESCALE);
  localparam logic [PS_W-1:0] PS_MAX = PS_W'(PRESCALE - 1);

  logic [PS_W-1:0]  ps;
  logic             qual;
  logic             step;
  logic             en_sec;
  logic             sec_wrap, min_wrap, hr_wrap;
  logic [SEC_W-1:0] sec_nxt;
  logic [MIN_W-1:0] min_nxt;
  logic [HR_W-1:0]  hr_nxt;

  assign qual   = bus.tick && bus.run;
  assign step   = qual && (ps == PS_MAX);
  // Load discards any step sampled in the same cycle.
  assign en_sec = step && !bus.load;

  always_ff @(posedge Clk or posedge reset) begin
    if (reset)         ps <= '0;
    else if (bus.load) ps <= '0;
    else if (qual)     ps <= step ? '0 : ps + 1'b1;
  end

  mod_counter #(.MOD(SEC_MOD), .W(SEC_W)) u_sec (
    .clk(Clk), .rst(reset), .en(en_sec), .dn(bus.down), .ld(bus.load),
    .ld_val(bus.load_sec), .val(bus.seconds), .nxt(sec_nxt), .wrap(sec_wrap)
  );

  mod_counter #(.MOD(MIN_MOD), .W(MIN_W)) u_min (
    .clk(Clk), .rst(reset), .en(sec_wrap), .dn(bus.down), .ld(bus.load),
    .ld_val(bus.load_min), .val(bus.minutes), .nxt(min_nxt), .wrap(min_wrap)
  );

  mod_counter #(.MOD(HR_MOD), .W(HR_W)) u_hr (
    .clk(Clk), .rst(reset), .en(min_wrap), .dn(bus.down), .ld(bus.load),
    .ld_val(bus.load_hr), .val(bus.hours), .nxt(hr_nxt), .wrap(hr_wrap)
  );

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      bus.min_pulse <= 1'b0;
      bus.day_pulse <= 1'b0;
    end else begin
      bus.min_pulse <= sec_wrap;
      bus.day_pulse <= hr_wrap;
    end
  end

`ifdef WATCH_TIMEKEEPER_ALARM_EN
  time_t alarm_t;
  time_t nxt_t;
  logic  armed;
  logic  fire;

  assign nxt_t = '{hr: FIELD_W'(hr_nxt), min: FIELD_W'(min_nxt), sec: FIELD_W'(sec_nxt)};
  // Only a real step can fire; loads never match because en_sec is low.
  assign fire  = armed && en_sec && (nxt_t == alarm_t);

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      alarm_t        <= '0;
      armed          <= 1'b0;
      bus.alarm_flag <= 1'b0;
    end else begin
      if (bus.alarm_set) begin
        alarm_t <= '{hr: FIELD_W'(bus.alarm_hr), min: FIELD_W'(bus.alarm_min), sec: '0};
        armed   <= 1'b1;
      end
      if (fire)               bus.alarm_flag <= 1'b1;
      else if (bus.alarm_clr) bus.alarm_flag <= 1'b0;
    end
  end
`else
  logic unused_nxt;
  assign unused_nxt = ^{sec_nxt, min_nxt, hr_nxt};
`endif

endmodule

// File: tb/tb_watch_timekeeper.sv
// Directed bench for watch_timekeeper: vector table on a PRESCALE=1 instance
// plus hand sequences for async reset, prescaler accumulation and alarm.
module tb_watch_timekeeper;
  import watch_pkg::*;

  logic Clk = 1'b0;
  logic reset;
  always #5 Clk = ~Clk;

  watch_timekeeper_if #(.SEC_W(6), .MIN_W(6), .HR_W(5)) b1 ();
  watch_timekeeper_if #(.SEC_W(6), .MIN_W(6), .HR_W(5)) b4 ();

  watch_timekeeper #(.PRESCALE(1)) dut1 (.Clk(Clk), .reset(reset), .bus(b1));
  watch_timekeeper #(.PRESCALE(4)) dut4 (.Clk(Clk), .reset(reset), .bus(b4));

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit ld; int ls; int lm; int lh;
    bit tk; bit dn; bit rn;
    int es; int em; int eh;
    bit emp; bit edp;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs[NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input int h, input int m, input int s,
                      input bit mp, input bit dp);
    chk({name, ".sec"}, 32'(b1.seconds),   32'(s));
    chk({name, ".min"}, 32'(b1.minutes),   32'(m));
    chk({name, ".hr"},  32'(b1.hours),     32'(h));
    chk({name, ".mp"},  32'(b1.min_pulse), 32'(mp));
    chk({name, ".dp"},  32'(b1.day_pulse), 32'(dp));
  endtask

  task automatic chk4(input string name, input int h, input int m, input int s);
    chk({name, ".sec"}, 32'(b4.seconds), 32'(s));
    chk({name, ".min"}, 32'(b4.minutes), 32'(m));
    chk({name, ".hr"},  32'(b4.hours),   32'(h));
  endtask

  task automatic idle1();
    b1.tick = 0; b1.run = 1; b1.down = 0; b1.load = 0;
    b1.load_sec = '0; b1.load_min = '0; b1.load_hr = '0;
  endtask

  task automatic load1(input int h, input int m, input int s);
    @(negedge Clk);
    idle1();
    b1.load = 1; b1.load_hr = 5'(h); b1.load_min = 6'(m); b1.load_sec = 6'(s);
    @(negedge Clk);
    idle1();
  endtask

  // One cycle on the PRESCALE=4 instance, then sample on the next negedge.
  task automatic cyc4(input bit t, input bit r, input bit ld);
    @(negedge Clk);
    b4.tick = t; b4.run = r; b4.load = ld;
    @(negedge Clk);
    b4.tick = 0; b4.load = 0;
  endtask

  initial begin
    //           ld  ls  lm  lh tk dn rn  es  em  eh mp dp
    vecs[0]  = '{1, 59, 59, 23, 0, 0, 1, 59, 59, 23, 0, 0};
    vecs[1]  = '{0,  0,  0,  0, 1, 0, 1,  0,  0,  0, 1, 1};
    vecs[2]  = '{0,  0,  0,  0, 0, 0, 1,  0,  0,  0, 0, 0};
    vecs[3]  = '{0,  0,  0,  0, 1, 1, 1, 59, 59, 23, 1, 1};
    vecs[4]  = '{0,  0,  0,  0, 1, 0, 1,  0,  0,  0, 1, 1};
    vecs[5]  = '{1, 56, 34, 12, 0, 0, 1, 56, 34, 12, 0, 0};
    vecs[6]  = '{1, 62, 60, 24, 0, 0, 1,  0,  0,  0, 0, 0};
    vecs[7]  = '{1, 59, 60, 23, 0, 0, 1, 59,  0, 23, 0, 0};
    vecs[8]  = '{1, 56, 34, 12, 1, 0, 1, 56, 34, 12, 0, 0};
    vecs[9]  = '{0,  0,  0,  0, 1, 0, 1, 57, 34, 12, 0, 0};
    vecs[10] = '{0,  0,  0,  0, 1, 0, 0, 57, 34, 12, 0, 0};
    vecs[11] = '{1, 59, 59,  0, 1, 0, 1, 59, 59,  0, 0, 0};
    vecs[12] = '{0,  0,  0,  0, 1, 0, 1,  0,  0,  1, 1, 0};
    vecs[13] = '{1,  0,  0, 10, 0, 0, 1,  0,  0, 10, 0, 0};
    vecs[14] = '{0,  0,  0,  0, 1, 1, 1, 59, 59,  9, 1, 0};
    vecs[15] = '{1, 42, 17,  5, 1, 1, 0, 42, 17,  5, 0, 0};
    vecs[16] = '{0,  0,  0,  0, 1, 1, 1, 41, 17,  5, 0, 0};
    vecs[17] = '{1, 42, 17,  5, 0, 0, 1, 42, 17,  5, 0, 0};

    reset = 1;
    idle1();
    b4.tick = 0; b4.run = 1; b4.down = 0; b4.load = 0;
    b4.load_sec = '0; b4.load_min = '0; b4.load_hr = '0;
`ifdef WATCH_TIMEKEEPER_ALARM_EN
    b1.alarm_set = 0; b1.alarm_hr = '0; b1.alarm_min = '0; b1.alarm_clr = 0;
    b4.alarm_set = 0; b4.alarm_hr = '0; b4.alarm_min = '0; b4.alarm_clr = 0;
`endif
    repeat (2) @(negedge Clk);
    chk1("reset", 0, 0, 0, 0, 0);
    chk4("reset4", 0, 0, 0);
    reset = 0;

    for (int i = 0; i < NV; i++) begin
      @(negedge Clk);
      b1.load = vecs[i].ld;
      b1.load_sec = 6'(vecs[i].ls); b1.load_min = 6'(vecs[i].lm); b1.load_hr = 5'(vecs[i].lh);
      b1.tick = vecs[i].tk; b1.down = vecs[i].dn; b1.run = vecs[i].rn;
      @(negedge Clk);
      chk1($sformatf("vec%0d", i), vecs[i].eh, vecs[i].em, vecs[i].es,
           vecs[i].emp, vecs[i].edp);
      idle1();
    end

    // Async reset at 05:17:42, between clock edges.
    #2 reset = 1;
    #1 chk1("async_reset", 0, 0, 0, 0, 0);
    @(negedge Clk);
    reset = 0;
    b1.tick = 1;
    @(negedge Clk);
    idle1();
    chk1("after_reset", 0, 0, 1, 0, 0);

    // PRESCALE=4: 8 ticks, run low on the 3rd and 6th.
    for (int i = 1; i <= 8; i++) begin
      cyc4(1, !(i == 3 || i == 6), 0);
      if (i == 4) chk4("ps_before_step", 0, 0, 0);
      if (i == 5) chk4("ps_step", 0, 0, 1);
    end
    chk4("ps_8ticks", 0, 0, 1);
    cyc4(1, 1, 0);
    chk4("ps_accum7", 0, 0, 1);
    cyc4(1, 1, 0);
    chk4("ps_accum8", 0, 0, 2);
    // Load clears a partially filled prescaler.
    cyc4(1, 1, 0);
    cyc4(0, 1, 1);
    repeat (3) cyc4(1, 1, 0);
    chk4("ps_load_clear3", 0, 0, 0);
    cyc4(1, 1, 0);
    chk4("ps_load_clear4", 0, 0, 1);

`ifdef WATCH_TIMEKEEPER_ALARM_EN
    @(negedge Clk);
    b1.alarm_set = 1; b1.alarm_hr = 5'd7; b1.alarm_min = 6'd30;
    @(negedge Clk);
    b1.alarm_set = 0;
    load1(7, 30, 0);
    chk("alarm_load_nofire", 32'(b1.alarm_flag), 32'd0);
    load1(7, 29, 59);
    @(negedge Clk);
    b1.tick = 1;
    @(negedge Clk);
    idle1();
    chk1("alarm_step", 7, 30, 0, 1, 0);
    chk("alarm_fire", 32'(b1.alarm_flag), 32'd1);
    @(negedge Clk);
    chk("alarm_sticky", 32'(b1.alarm_flag), 32'd1);
    b1.alarm_clr = 1;
    @(negedge Clk);
    b1.alarm_clr = 0;
    chk("alarm_clr", 32'(b1.alarm_flag), 32'd0);
`else
    load1(7, 30, 0);
    chk1("final_load", 7, 30, 0, 0, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

endmodule
